mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 70 +++++++
 rtl/mc_controller_if.sv | 33 +++
 rtl/mc_controller_outdec.sv | 82 ++++++++
 rtl/mc_controller.sv | 79 +++++++
 tb/tb_mc_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
//==============================================================================
// mc_controller_pkg : opcodes, datapath select encodings, FSM states, ctrl vector
// Rev 1.0
//==============================================================================
`default_nettype none

package mc_controller_pkg;

   localparam int         c_op_w       = 6;

   localparam logic [5:0] c_op_rtype   = 6'b000000;
   localparam logic [5:0] c_op_j       = 6'b000010;
   localparam logic [5:0] c_op_beq     = 6'b000100;
   localparam logic [5:0] c_op_addi    = 6'b001000;
   localparam logic [5:0] c_op_ori     = 6'b001101;
   localparam logic [5:0] c_op_lw      = 6'b100011;
   localparam logic [5:0] c_op_sw      = 6'b101011;

   localparam logic [1:0] c_aluop_add  = 2'b00;
   localparam logic [1:0] c_aluop_sub  = 2'b01;
   localparam logic [1:0] c_aluop_fn   = 2'b10;
   localparam logic [1:0] c_aluop_or   = 2'b11;

   localparam logic [1:0] c_srcb_regb  = 2'b00;
   localparam logic [1:0] c_srcb_four  = 2'b01;
   localparam logic [1:0] c_srcb_imm   = 2'b10;
   localparam logic [1:0] c_srcb_immsh = 2'b11;

   localparam logic [1:0] c_pcsrc_alu  = 2'b00;
   localparam logic [1:0] c_pcsrc_out  = 2'b01;
   localparam logic [1:0] c_pcsrc_jmp  = 2'b10;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
      MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
      BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ORIEX   = 4'd10, IMMWB   = 4'd11,
      JEX     = 4'd12
   } state_t;

   // memgate: enables wait on mem_ready; branch: pcen waits on zero;
   // decode: the state in which an unknown opcode raises illegal
   typedef struct packed {
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic       zeroext;
      logic       pcen;
      logic       memgate;
      logic       branch;
      logic       decode;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [c_op_w-1:0] op);
      case (op)
         c_op_lw, c_op_sw, c_op_rtype, c_op_beq,
         c_op_addi, c_op_ori, c_op_j: is_legal_op = 1'b1;
         default:                     is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_if.sv
//==============================================================================
// mc_if : opcode/flag inputs and control outputs of the multicycle controller
// Rev 1.0
//==============================================================================
`default_nettype none

interface mc_if;
   import mc_controller_pkg::*;

   logic [c_op_w-1:0] op;
   logic              zero;
   logic              mem_ready;
   logic              iord, irwrite, memwrite, regwrite, regdst;
   logic              memtoreg, alusrca, zeroext, pcen, illegal;
   logic [1:0]        alusrcb, pcsrc, aluop;

   modport master (
      output op, zero, mem_ready,
      input  iord, irwrite, memwrite, regwrite, regdst,
             memtoreg, alusrca, zeroext, pcen, illegal,
             alusrcb, pcsrc, aluop
   );

   modport slave (
      input  op, zero, mem_ready,
      output iord, irwrite, memwrite, regwrite, regdst,
             memtoreg, alusrca, zeroext, pcen, illegal,
             alusrcb, pcsrc, aluop
   );

endinterface

`default_nettype wire

// File: rtl/mc_controller_outdec.sv
//==============================================================================
// mc_outdec : state register -> unqualified control vector (pure Moore decode)
// Rev 1.0
//==============================================================================
`default_nettype none

module mc_outdec
   import mc_controller_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  wire logic [STATE_W-1:0] i_state,
   output ctrl_t                   o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         STATE_W'(FETCH): begin
            o_ctrl.alusrcb = c_srcb_four;
            o_ctrl.irwrite = 1'b1;
            o_ctrl.pcen    = 1'b1;
            o_ctrl.memgate = 1'b1;
         end
         STATE_W'(DECODE): begin
            o_ctrl.alusrcb = c_srcb_immsh;
            o_ctrl.decode  = 1'b1;
         end
         STATE_W'(MEMADR): begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = c_srcb_imm;
         end
         STATE_W'(MEMRD):  o_ctrl.iord = 1'b1;
         STATE_W'(MEMWR): begin
            o_ctrl.iord     = 1'b1;
            o_ctrl.memwrite = 1'b1;
            o_ctrl.memgate  = 1'b1;
         end
         STATE_W'(MEMWB): begin
            o_ctrl.memtoreg = 1'b1;
            o_ctrl.regwrite = 1'b1;
         end
         STATE_W'(RTYPEEX): begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = c_srcb_regb;
            o_ctrl.aluop   = c_aluop_fn;
         end
         STATE_W'(RTYPEWB): begin
            o_ctrl.regdst   = 1'b1;
            o_ctrl.regwrite = 1'b1;
         end
         STATE_W'(BEQEX): begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = c_srcb_regb;
            o_ctrl.aluop   = c_aluop_sub;
            o_ctrl.pcsrc   = c_pcsrc_out;
            o_ctrl.pcen    = 1'b1;
            o_ctrl.branch  = 1'b1;
         end
         STATE_W'(ADDIEX): begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = c_srcb_imm;
            o_ctrl.aluop   = c_aluop_add;
         end
         STATE_W'(ORIEX): begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = c_srcb_imm;
            o_ctrl.aluop   = c_aluop_or;
            o_ctrl.zeroext = 1'b1;
         end
         STATE_W'(IMMWB):  o_ctrl.regwrite = 1'b1;
         STATE_W'(JEX): begin
            o_ctrl.pcsrc = c_pcsrc_jmp;
            o_ctrl.pcen  = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
//==============================================================================
// mc_controller : multicycle CPU control FSM with mem_ready / zero / reset gating
// Rev 1.0
//==============================================================================
`default_nettype none

module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  wire logic clk,
   input  wire logic reset,
   mc_if.slave       bus
);

   logic [STATE_W-1:0] r_state;
   ctrl_t              w_ctrl;
   logic               w_ready_ok;
   logic               w_zero_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= STATE_W'(FETCH);
      end else begin
         case (r_state)
            STATE_W'(FETCH):   if (bus.mem_ready) r_state <= STATE_W'(DECODE);
            STATE_W'(DECODE): begin
               case (bus.op)
                  c_op_lw, c_op_sw: r_state <= STATE_W'(MEMADR);
                  c_op_rtype:       r_state <= STATE_W'(RTYPEEX);
                  c_op_beq:         r_state <= STATE_W'(BEQEX);
                  c_op_addi:        r_state <= STATE_W'(ADDIEX);
                  c_op_ori:         r_state <= STATE_W'(ORIEX);
                  c_op_j:           r_state <= STATE_W'(JEX);
                  default:          r_state <= STATE_W'(FETCH);
               endcase
            end
            STATE_W'(MEMADR):  r_state <= (bus.op == c_op_lw) ? STATE_W'(MEMRD)
                                                              : STATE_W'(MEMWR);
            STATE_W'(MEMRD):   if (bus.mem_ready) r_state <= STATE_W'(MEMWB);
            STATE_W'(MEMWR):   if (bus.mem_ready) r_state <= STATE_W'(FETCH);
            STATE_W'(RTYPEEX): r_state <= STATE_W'(RTYPEWB);
            STATE_W'(ADDIEX),
            STATE_W'(ORIEX):   r_state <= STATE_W'(IMMWB);
            default:           r_state <= STATE_W'(FETCH);
         endcase
      end
   end

   mc_outdec #(
      .STATE_W (STATE_W)
   ) u_outdec (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   // Reset must suppress every write even mid-access, hence the combinational gate
   assign w_ready_ok   = ~w_ctrl.memgate | bus.mem_ready;
   assign w_zero_ok    = ~w_ctrl.branch  | bus.zero;

   assign bus.irwrite  = ~reset & w_ctrl.irwrite  & w_ready_ok;
   assign bus.memwrite = ~reset & w_ctrl.memwrite & w_ready_ok;
   assign bus.pcen     = ~reset & w_ctrl.pcen     & w_ready_ok & w_zero_ok;
   assign bus.regwrite = ~reset & w_ctrl.regwrite;
   assign bus.illegal  = ~reset & w_ctrl.decode   & ~is_legal_op(bus.op);

   assign bus.iord     = w_ctrl.iord;
   assign bus.regdst   = w_ctrl.regdst;
   assign bus.memtoreg = w_ctrl.memtoreg;
   assign bus.alusrca  = w_ctrl.alusrca;
   assign bus.zeroext  = w_ctrl.zeroext;
   assign bus.alusrcb  = w_ctrl.alusrcb;
   assign bus.pcsrc    = w_ctrl.pcsrc;
   assign bus.aluop    = w_ctrl.aluop;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
//==============================================================================
// tb_mc_controller : instruction-script model of mc_controller, randomized traffic
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_mc_controller;

   typedef struct packed {
      logic       iord, irwrite, memwrite, regwrite, regdst;
      logic       memtoreg, alusrca, zeroext, pcen, illegal;
      logic [1:0] alusrcb, pcsrc, aluop;
   } outs_t;

   typedef struct {
      bit         rst;
      bit         mr;
      bit         zr;
      logic [5:0] op;
      outs_t      o;
   } ent_t;

   logic clk;
   logic reset;
   mc_if bus ();

   mc_controller #(.STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                          BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101,
                          JMP = 6'b000010;

   function automatic bit legal(input logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ ||
             op == ADDI || op == ORI || op == JMP;
   endfunction

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ent_t ent(input logic [5:0] op, input bit mr, input bit zr,
                                input outs_t o);
      ent_t e;
      e.rst = 1'b0; e.mr = mr; e.zr = zr; e.op = op; e.o = o;
      return e;
   endfunction

   // Expected cycle-by-cycle script of one instruction: wf fetch stalls, wm memory
   // stalls, optional reset at cycle index 'abort' which truncates the instruction.
   task automatic gen(input logic [5:0] op, input bit z, input int wf, input int wm,
                      input int abort);
      ent_t  t[$];
      ent_t  e;
      outs_t o;
      for (int i = 0; i < wf; i++) begin
         o = '0; o.alusrcb = 2'b01;
         t.push_back(ent(op, 1'b0, rbit(), o));
      end
      o = '0; o.alusrcb = 2'b01; o.irwrite = 1'b1; o.pcen = 1'b1;
      t.push_back(ent(op, 1'b1, rbit(), o));
      o = '0; o.alusrcb = 2'b11; o.illegal = !legal(op);
      t.push_back(ent(op, rbit(), rbit(), o));
      if (op == LW || op == SW) begin
         o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
         t.push_back(ent(op, rbit(), rbit(), o));
         for (int i = 0; i < wm; i++) begin
            o = '0; o.iord = 1'b1;
            t.push_back(ent(op, 1'b0, rbit(), o));
         end
         o = '0; o.iord = 1'b1; o.memwrite = (op == SW);
         t.push_back(ent(op, 1'b1, rbit(), o));
         if (op == LW) begin
            o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1;
            t.push_back(ent(op, rbit(), rbit(), o));
         end
      end else if (op == RT) begin
         o = '0; o.alusrca = 1'b1; o.aluop = 2'b10;
         t.push_back(ent(op, rbit(), rbit(), o));
         o = '0; o.regdst = 1'b1; o.regwrite = 1'b1;
         t.push_back(ent(op, rbit(), rbit(), o));
      end else if (op == BEQ) begin
         o = '0; o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z;
         t.push_back(ent(op, rbit(), z, o));
      end else if (op == ADDI || op == ORI) begin
         o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
         o.aluop = (op == ORI) ? 2'b11 : 2'b00; o.zeroext = (op == ORI);
         t.push_back(ent(op, rbit(), rbit(), o));
         o = '0; o.regwrite = 1'b1;
         t.push_back(ent(op, rbit(), rbit(), o));
      end else if (op == JMP) begin
         o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1;
         t.push_back(ent(op, rbit(), rbit(), o));
      end
      if (abort >= 0 && abort < t.size()) begin
         while (t.size() > abort + 1) void'(t.pop_back());
         e = t[abort];
         e.rst = 1'b1;
         e.o.irwrite = 1'b0; e.o.memwrite = 1'b0; e.o.regwrite = 1'b0;
         e.o.pcen = 1'b0; e.o.illegal = 1'b0;
         t[abort] = e;
      end
      foreach (t[i]) q.push_back(t[i]);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic outs_t dut_outs();
      outs_t o;
      o.iord = bus.iord; o.irwrite = bus.irwrite; o.memwrite = bus.memwrite;
      o.regwrite = bus.regwrite; o.regdst = bus.regdst; o.memtoreg = bus.memtoreg;
      o.alusrca = bus.alusrca; o.zeroext = bus.zeroext; o.pcen = bus.pcen;
      o.illegal = bus.illegal; o.alusrcb = bus.alusrcb; o.pcsrc = bus.pcsrc;
      o.aluop = bus.aluop;
      return o;
   endfunction

   logic [5:0] ops [7];
   ent_t       e;
   outs_t      exp_o;
   int         cyc;
   int         k, wf, wm, ab, nmw;
   logic [5:0] rop;

   initial begin
      ops = '{LW, SW, RT, BEQ, ADDI, ORI, JMP};
      reset = 1'b1; bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

      // Hand-derived latencies and key cycles pin the script model
      q.delete(); gen(LW, 1'b0, 0, 0, -1);
      chk("pin_lw_len", 32'(q.size()), 32'd5);
      chk("pin_lw_wb", {30'd0, q[4].o.regwrite, q[4].o.memtoreg}, 32'h3);
      chk("pin_lw_c4_nowr", 32'(q[3].o.regwrite), 32'd0);
      q.delete(); gen(SW, 1'b0, 0, 2, -1);
      chk("pin_sw_len", 32'(q.size()), 32'd6);
      nmw = 0;
      foreach (q[i]) nmw += int'(q[i].o.memwrite);
      chk("pin_sw_memwrite_once", 32'(nmw), 32'd1);
      q.delete(); gen(BEQ, 1'b1, 0, 0, -1);
      chk("pin_beq_len", 32'(q.size()), 32'd3);
      chk("pin_beq_pc", {29'd0, q[2].o.pcen, q[2].o.pcsrc}, 32'h5);
      q.delete(); gen(6'b111111, 1'b0, 0, 0, -1);
      chk("pin_ill_len", 32'(q.size()), 32'd2);
      chk("pin_ill_flag", 32'(q[1].o.illegal), 32'd1);
      q.delete();

      // Reset holds FETCH with every write enable forced low even with mem_ready=1
      @(negedge clk); #2;
      exp_o = '0; exp_o.alusrcb = 2'b01;
      chk("reset_fetch", 32'(dut_outs()), 32'(exp_o));

      gen(LW,   1'b0, 0, 0, -1);
      gen(SW,   1'b0, 0, 2, -1);
      gen(BEQ,  1'b1, 0, 0, -1);
      gen(BEQ,  1'b0, 0, 0, -1);
      gen(ORI,  1'b0, 0, 0, -1);
      gen(6'b111111, 1'b0, 0, 0, -1);
      gen(LW,   1'b0, 0, 3, 3);
      gen(SW,   1'b0, 1, 3, 4);
      gen(ADDI, 1'b0, 2, 0, -1);
      gen(RT,   1'b0, 0, 0, -1);
      gen(JMP,  1'b0, 0, 0, -1);
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 8);
         if (k == 8) begin
            rop = 6'($urandom);
            if (legal(rop)) rop = 6'b111111;
         end else begin
            rop = ops[k % 7];
         end
         wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
         gen(rop, rbit(), wf, wm, ab);
      end

      cyc = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(negedge clk);
         reset = e.rst; bus.op = e.op; bus.mem_ready = e.mr; bus.zero = e.zr;
         #2;
         checks++;
         if (dut_outs() !== e.o) begin
            errors++;
            $display("FAIL cycle cyc=%0d op=%b rst=%0d mr=%0d zr=%0d got=%h exp=%h",
                     cyc, e.op, e.rst, e.mr, e.zr, dut_outs(), e.o);
         end
         cyc++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
